// File: rtl/ysyx_040729_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_040729_ifu_fetch
// Brief    : Instruction fetch unit; single-outstanding imem fetch feeding a
//            small in-order instruction FIFO toward the decoder.
// Revision : 1.0
// ============================================================================
module ysyx_040729_ifu_fetch #(
    parameter int                    INST_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h80000000,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    input  logic                  imem_resp_err,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_fault
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_halt_after_drop;
    logic                  w_halt_after_drop_nxt;

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_inflight_pc;
    logic [INST_WIDTH-1:0] r_inst_mem  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc_mem    [FIFO_DEPTH];
    logic                  r_fault_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_not_full;
    logic                  w_req_hs;
    logic                  w_misaligned;
    logic                  w_stale;
    logic                  w_push;
    logic                  w_pop;

    assign w_not_full     = r_count < CNT_W'(FIFO_DEPTH);
    assign imem_req_valid = !rst && (r_state == S_REQ) && w_not_full;
    assign imem_req_addr  = r_pc;
    assign w_req_hs       = imem_req_valid && imem_req_ready;
    assign w_misaligned   = redirect_pc[1:0] != 2'b00;
    // A request whose response has not yet arrived (or is issued right now)
    // will still come back and must be swallowed after a redirect.
    assign w_stale        = ((r_state == S_WAIT) && !imem_resp_valid) || w_req_hs ||
                            ((r_state == S_DROP) && !imem_resp_valid);
    assign w_push         = (r_state == S_WAIT) && imem_resp_valid && !redirect_valid;
    assign w_pop          = inst_valid && inst_ready;

    assign inst_valid     = r_count != '0;
    assign inst           = r_inst_mem[r_rd_ptr];
    assign inst_pc        = r_pc_mem[r_rd_ptr];
    assign inst_fault     = r_fault_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= S_REQ;
            r_halt_after_drop <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_halt_after_drop <= w_halt_after_drop_nxt;
        end
    end

    always_comb begin
        w_state_nxt           = r_state;
        w_halt_after_drop_nxt = r_halt_after_drop;
        if (redirect_valid) begin
            if (w_stale) begin
                w_state_nxt           = S_DROP;
                w_halt_after_drop_nxt = w_misaligned;
            end else begin
                w_state_nxt           = w_misaligned ? S_HALT : S_REQ;
                w_halt_after_drop_nxt = 1'b0;
            end
        end else begin
            case (r_state)
                S_REQ:  if (w_req_hs) w_state_nxt = S_WAIT;
                S_WAIT: if (imem_resp_valid) w_state_nxt = imem_resp_err ? S_HALT : S_REQ;
                S_DROP: begin
                    if (imem_resp_valid) begin
                        w_state_nxt           = r_halt_after_drop ? S_HALT : S_REQ;
                        w_halt_after_drop_nxt = 1'b0;
                    end
                end
                default: w_state_nxt = S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inflight_pc <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_inst_mem[i]  <= '0;
                r_pc_mem[i]    <= '0;
                r_fault_mem[i] <= 1'b0;
            end
        end else if (redirect_valid) begin
            r_pc     <= redirect_pc;
            r_rd_ptr <= '0;
            if (w_misaligned) begin
                r_inst_mem[0]  <= '0;
                r_pc_mem[0]    <= redirect_pc;
                r_fault_mem[0] <= 1'b1;
                r_wr_ptr       <= PTR_W'(1);
                r_count        <= CNT_W'(1);
            end else begin
                r_wr_ptr <= '0;
                r_count  <= '0;
            end
        end else begin
            if (w_req_hs) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + ADDR_WIDTH'(4);
            end
            if (w_push) begin
                r_inst_mem[r_wr_ptr]  <= imem_resp_err ? '0 : imem_resp_data;
                r_pc_mem[r_wr_ptr]    <= r_inflight_pc;
                r_fault_mem[r_wr_ptr] <= imem_resp_err;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
